ntm_read_keys: RTL and testbench
================================

Name: ntm_read_keys

Overview:
- Read-side counterpart of the DNC write-head interface. It accepts the R×W read-key matrix k(t,i;j) from the controller interface vector and delivers it element by element to the read-head content addressing.
- It uses the same START/READY and *_ENABLE strobe protocol as the write-key path, extended to two dimensions: i is the read head and j is the word element.
- It sits inside the dnc read_heads cluster, beside the read strength, free gate and read mode blocks.

Parameters:
- DATA_SIZE, 64, width of data and size ports.
- CONTROL_SIZE, 64, width of the internal index counters.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- START  in  1  one-cycle pulse that begins a matrix transfer.
- READY  out  1  one-cycle pulse when the last element has been output.
- K_IN_ENABLE  in  1  K_IN is valid this cycle.
- K_OUT_I_ENABLE  out  1  pulse on the first element (j=0) of each head.
- K_OUT_J_ENABLE  out  1  pulse on every element output.
- SIZE_R_IN  in  DATA_SIZE  number of read heads, R; latched at START.
- SIZE_W_IN  in  DATA_SIZE  word size, W; latched at START.
- K_IN  in  DATA_SIZE  key element input.
- K_OUT  out  DATA_SIZE  registered key element output.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values: READY=0, K_OUT_I_ENABLE=0, K_OUT_J_ENABLE=0, K_OUT=0, i=0, j=0, latched sizes=0, state=STARTER.
- FSM states: STARTER, INPUT_STATE, ENDER.
- STARTER:
  - On START=1, latch SIZE_R_IN and SIZE_W_IN, clear i and j, go to INPUT_STATE.
  - If either latched size is 0, go to ENDER instead.
  - K_IN_ENABLE is ignored in this state.
- INPUT_STATE, each cycle with K_IN_ENABLE=1:
  - Next edge: K_OUT<=K_IN and K_OUT_J_ENABLE<=1.
  - K_OUT_I_ENABLE<=1 if j==0.
  - Latency from K_IN_ENABLE to output is exactly 1 cycle. Throughput is one element per cycle, so back-to-back enables are legal.
- Counter update per accepted element:
  - If j==W-1: j<=0 and i<=i+1.
  - Otherwise: j<=j+1.
- Last element: when i==R-1 and j==W-1 are accepted, READY<=1 in the same edge as that element's K_OUT_J_ENABLE. The FSM then returns to STARTER and counters clear.
- Cycles with K_IN_ENABLE=0 in INPUT_STATE: all strobes 0, K_OUT holds, no counter change.
- ENDER (zero-size case only): READY=1 for one cycle with no element strobes, then STARTER. READY therefore comes 2 cycles after START.
- Strobes are single-cycle and deasserted on the following edge unless retriggered.
- K_OUT holds its last value between elements and after READY.
- START while in INPUT_STATE or ENDER is ignored; sizes are not relatched.
- START and last-element acceptance in the same cycle: the START is ignored. A new START is only accepted in STARTER, i.e. the cycle after READY or later.
- RST asserted mid-transfer: immediate return to reset values. No READY is produced for the aborted transfer.
- Counters are CONTROL_SIZE-bit unsigned. Compares are against the latched size minus 1; sizes ≥ 1 are guaranteed non-wrapping.
- Data is passed unmodified with no arithmetic on K.

Decomposition:
- Shared package ntm_dnc_pkg:
  - State enum (STARTER, INPUT_STATE, ENDER), reused by the other read-head blocks.
  - Constants ZERO_CONTROL, ONE_CONTROL, ZERO_DATA.
- One sub-module is natural: ntm_matrix_index_counter.
  - Holds the 2-D i/j counter with wrap.
  - Produces first_j and last_element flags.
  - Reused by the read-mode and read-weighting blocks.

Test Plan:
- R=2, W=3, START, then K_IN=1..6 on 6 consecutive enabled cycles:
  - K_OUT=1..6, each one cycle after its input.
  - K_OUT_I_ENABLE on elements 1 and 4.
  - READY coincident with K_OUT=6.
  - No further strobes.
- R=1, W=4 with K_IN_ENABLE gapped (cycles 0, 3, 4, 9):
  - Outputs only on the cycles following enables.
  - K_OUT holds between elements.
  - READY with the 4th element.
- SIZE_R_IN=0, W=5, START: READY 2 cycles after START, no J/I strobes, K_OUT unchanged.
- START pulsed again mid-transfer (R=2, W=2) with new sizes R=9, W=9:
  - Ignored; the transfer completes after 4 elements with READY.
  - A subsequent START after READY latches the new sizes.
- RST pulsed after 3 of 6 elements:
  - All outputs 0 asynchronously.
  - A fresh START with R=1, W=1 and K_IN=0xAA gives K_OUT=0xAA, I/J strobes and READY in the same cycle.
- K_IN_ENABLE pulses while in STARTER before any START: no output strobes, K_OUT stays 0.

Source files
------------

// File: rtl/ntm_dnc_pkg.sv
// Shared types and constants for the DNC read-head cluster blocks.
package ntm_dnc_pkg;

  typedef enum logic [1:0] {
    STARTER,
    INPUT_STATE,
    ENDER
  } state_t;

  localparam logic [63:0] ZERO_CONTROL = 64'd0;
  localparam logic [63:0] ONE_CONTROL  = 64'd1;
  localparam logic [63:0] ZERO_DATA    = 64'd0;

endpackage

// File: rtl/ntm_matrix_index_counter.sv
// Two-dimensional head/element index counter: j walks the word, i walks the heads.
module ntm_matrix_index_counter #(
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    advance,
  input  logic [CONTROL_SIZE-1:0] size_r,
  input  logic [CONTROL_SIZE-1:0] size_w,
  output logic                    first_j,
  output logic                    last_element
);
  import ntm_dnc_pkg::*;

  localparam logic [CONTROL_SIZE-1:0] CTRL_ZERO = CONTROL_SIZE'(ZERO_CONTROL);
  localparam logic [CONTROL_SIZE-1:0] CTRL_ONE  = CONTROL_SIZE'(ONE_CONTROL);

  logic [CONTROL_SIZE-1:0] index_i;
  logic [CONTROL_SIZE-1:0] index_j;
  logic                    last_j;

  assign first_j      = (index_j == CTRL_ZERO);
  assign last_j       = (index_j == size_w - CTRL_ONE);
  assign last_element = last_j && (index_i == size_r - CTRL_ONE);

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_i <= CTRL_ZERO;
      index_j <= CTRL_ZERO;
    end else if (clear || (advance && last_element)) begin
      // The final element wraps both counters so the next matrix starts at (0,0).
      index_i <= CTRL_ZERO;
      index_j <= CTRL_ZERO;
    end else if (advance) begin
      if (last_j) begin
        index_j <= CTRL_ZERO;
        index_i <= index_i + CTRL_ONE;
      end else begin
        index_j <= index_j + CTRL_ONE;
      end
    end
  end

endmodule

// File: rtl/ntm_read_keys.sv
// Streams the R x W read-key matrix to read-head content addressing, one element per strobe.
module ntm_read_keys #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 K_IN_ENABLE,
  output logic                 K_OUT_I_ENABLE,
  output logic                 K_OUT_J_ENABLE,
  input  logic [DATA_SIZE-1:0] SIZE_R_IN,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic [DATA_SIZE-1:0] K_IN,
  output logic [DATA_SIZE-1:0] K_OUT
);
  import ntm_dnc_pkg::*;

  state_t               state;
  logic [DATA_SIZE-1:0] size_r_q;
  logic [DATA_SIZE-1:0] size_w_q;
  logic                 accept;
  logic                 clear_cnt;
  logic                 zero_size;
  logic                 first_j;
  logic                 last_element;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    accept    = 1'b0;
    clear_cnt = 1'b0;
    zero_size = (SIZE_R_IN == '0) || (SIZE_W_IN == '0);
    if (state == INPUT_STATE) accept = K_IN_ENABLE;
    if (state == STARTER)     clear_cnt = START;
  end

  ntm_matrix_index_counter #(
    .CONTROL_SIZE(CONTROL_SIZE)
  ) u_index (
    .clk         (CLK),
    .rst         (RST),
    .clear       (clear_cnt),
    .advance     (accept),
    .size_r      (CONTROL_SIZE'(size_r_q)),
    .size_w      (CONTROL_SIZE'(size_w_q)),
    .first_j     (first_j),
    .last_element(last_element)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= STARTER;
      READY          <= 1'b0;
      K_OUT_I_ENABLE <= 1'b0;
      K_OUT_J_ENABLE <= 1'b0;
      K_OUT          <= DATA_SIZE'(ZERO_DATA);
      size_r_q       <= '0;
      size_w_q       <= '0;
    end else begin
      READY          <= 1'b0;
      K_OUT_I_ENABLE <= 1'b0;
      K_OUT_J_ENABLE <= 1'b0;
      case (state)
        STARTER: begin
          if (START) begin
            size_r_q <= SIZE_R_IN;
            size_w_q <= SIZE_W_IN;
            state    <= zero_size ? ENDER : INPUT_STATE;
          end
        end
        INPUT_STATE: begin
          // START is deliberately not looked at here: sizes stay fixed for the whole matrix.
          if (accept) begin
            K_OUT          <= K_IN;
            K_OUT_J_ENABLE <= 1'b1;
            K_OUT_I_ENABLE <= first_j;
            if (last_element) begin
              READY <= 1'b1;
              state <= STARTER;
            end
          end
        end
        ENDER: begin
          READY <= 1'b1;
          state <= STARTER;
        end
        default: state <= STARTER;
      endcase
    end
  end

endmodule

// File: tb/tb_ntm_read_keys.sv
// Self-checking bench for ntm_read_keys: directed vector table plus randomized transfers.
module tb_ntm_read_keys;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic        k_in_enable;
  logic        k_out_i_enable;
  logic        k_out_j_enable;
  logic [63:0] size_r_in;
  logic [63:0] size_w_in;
  logic [63:0] k_in;
  logic [63:0] k_out;

  int vectors    = 0;
  int miscompares = 0;
  logic [63:0] last_k;

  always #5 clk = ~clk;

  ntm_read_keys #(.DATA_SIZE(64), .CONTROL_SIZE(64)) dut (
    .CLK           (clk),
    .RST           (rst),
    .START         (start),
    .READY         (ready),
    .K_IN_ENABLE   (k_in_enable),
    .K_OUT_I_ENABLE(k_out_i_enable),
    .K_OUT_J_ENABLE(k_out_j_enable),
    .SIZE_R_IN     (size_r_in),
    .SIZE_W_IN     (size_w_in),
    .K_IN          (k_in),
    .K_OUT         (k_out)
  );

  typedef struct {
    logic        start;
    logic        en;
    logic [63:0] sr;
    logic [63:0] sw;
    logic [63:0] k;
    logic        rdy;
    logic        ie;
    logic        je;
    logic [63:0] ko;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic en, logic [63:0] sr, logic [63:0] sw,
                              logic [63:0] k, logic rdy, logic ie, logic je, logic [63:0] ko);
    vec_t v;
    v.start = st; v.en = en; v.sr = sr; v.sw = sw; v.k = k;
    v.rdy = rdy; v.ie = ie; v.je = je; v.ko = ko;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(string tag, logic rdy, logic ie, logic je, logic [63:0] ko);
    check({tag, ".ready"}, 64'(ready), 64'(rdy));
    check({tag, ".i_en"},  64'(k_out_i_enable), 64'(ie));
    check({tag, ".j_en"},  64'(k_out_j_enable), 64'(je));
    check({tag, ".k_out"}, k_out, ko);
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled at the same point.
  task automatic drive_step(logic st, logic en, logic [63:0] sr, logic [63:0] sw, logic [63:0] k);
    start = st; k_in_enable = en; size_r_in = sr; size_w_in = sw; k_in = k;
    @(posedge clk);
    #1;
  endtask

  // Reference: element n of an R x W matrix opens a head when n % W == 0, READY on n == R*W-1.
  task automatic run_transfer(int r, int w, int gap_pct, bit noise_start);
    int total = r * w;
    int n = 0;
    logic en;
    logic [63:0] data;
    drive_step(1'b1, 1'b0, 64'(r), 64'(w), 64'($urandom));
    check_outs($sformatf("xfer%0dx%0d.start", r, w), 1'b0, 1'b0, 1'b0, last_k);
    if (total == 0) begin
      drive_step(1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
      check_outs($sformatf("xfer%0dx%0d.ender", r, w), 1'b1, 1'b0, 1'b0, last_k);
    end else begin
      while (n < total) begin
        en   = ($urandom_range(99) >= gap_pct);
        data = {$urandom, $urandom};
        drive_step(noise_start & 1'($urandom_range(1)), en,
                   64'($urandom_range(9)), 64'($urandom_range(9)), data);
        if (en) begin
          last_k = data;
          check_outs($sformatf("xfer%0dx%0d.e%0d", r, w, n), n == total - 1,
                     (n % w) == 0, 1'b1, last_k);
          n++;
        end else begin
          check_outs($sformatf("xfer%0dx%0d.gap", r, w), 1'b0, 1'b0, 1'b0, last_k);
        end
      end
    end
    drive_step(1'b0, 1'b1, 64'd0, 64'd0, 64'hdead);
    check_outs($sformatf("xfer%0dx%0d.after", r, w), 1'b0, 1'b0, 1'b0, last_k);
  endtask

  initial begin
    int e;
    logic [63:0] lk;

    // STARTER ignores enables before any START.
    tbl.push_back(mk(0, 1, 0, 0, 'h55, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 'h56, 0, 0, 0, 0));
    // R=2, W=3 back-to-back.
    tbl.push_back(mk(1, 0, 2, 3, 0, 0, 0, 0, 0));
    for (int n = 1; n <= 6; n++)
      tbl.push_back(mk(0, 1, 0, 0, 64'(n), n == 6, n == 1 || n == 4, 1, 64'(n)));
    tbl.push_back(mk(0, 0, 0, 0, 'h99, 0, 0, 0, 6));
    tbl.push_back(mk(0, 0, 0, 0, 'h98, 0, 0, 0, 6));
    // R=1, W=4, enables on cycles 0, 3, 4, 9.
    tbl.push_back(mk(1, 0, 1, 4, 0, 0, 0, 0, 6));
    e = 0; lk = 6;
    for (int c = 0; c < 10; c++) begin
      if (c == 0 || c == 3 || c == 4 || c == 9) begin
        lk = 64'('h40 + c);
        tbl.push_back(mk(0, 1, 0, 0, lk, e == 3, e == 0, 1, lk));
        e++;
      end else begin
        tbl.push_back(mk(0, 0, 0, 0, 64'('h40 + c), 0, 0, 0, lk));
      end
    end
    // Zero-size matrix: READY alone, two cycles after START.
    tbl.push_back(mk(1, 0, 0, 5, 0, 0, 0, 0, 'h49));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 'h49));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h49));
    // START mid-transfer and on the last element is ignored; START while READY shows is taken.
    tbl.push_back(mk(1, 0, 2, 2, 0, 0, 0, 0, 'h49));
    tbl.push_back(mk(0, 1, 0, 0, 'h21, 0, 1, 1, 'h21));
    tbl.push_back(mk(1, 1, 9, 9, 'h22, 0, 0, 1, 'h22));
    tbl.push_back(mk(0, 1, 0, 0, 'h23, 0, 1, 1, 'h23));
    tbl.push_back(mk(1, 1, 9, 9, 'h24, 1, 0, 1, 'h24));
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0, 'h24));
    tbl.push_back(mk(0, 1, 0, 0, 'h31, 0, 1, 1, 'h31));
    tbl.push_back(mk(0, 1, 0, 0, 'h32, 1, 0, 1, 'h32));
    tbl.push_back(mk(0, 1, 0, 0, 'h77, 0, 0, 0, 'h32));

    rst = 1'b1; start = 1'b0; k_in_enable = 1'b0;
    size_r_in = '0; size_w_in = '0; k_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 64'd0);
    rst = 1'b0;

    foreach (tbl[idx]) begin
      drive_step(tbl[idx].start, tbl[idx].en, tbl[idx].sr, tbl[idx].sw, tbl[idx].k);
      check_outs($sformatf("vec%0d", idx), tbl[idx].rdy, tbl[idx].ie, tbl[idx].je, tbl[idx].ko);
    end

    // Asynchronous reset after 3 of 6 elements, then a 1x1 matrix.
    drive_step(1'b1, 1'b0, 64'd2, 64'd3, 64'd0);
    for (int n = 1; n <= 3; n++) drive_step(1'b0, 1'b1, 64'd0, 64'd0, 64'(n));
    check_outs("pre_rst", 1'b0, 1'b0, 1'b1, 64'd3);
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 1'b0, 1'b0, 1'b0, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_step(1'b0, 1'b1, 64'd0, 64'd0, 64'h5);
    check_outs("post_rst_idle", 1'b0, 1'b0, 1'b0, 64'd0);
    drive_step(1'b1, 1'b0, 64'd1, 64'd1, 64'd0);
    check_outs("one_start", 1'b0, 1'b0, 1'b0, 64'd0);
    drive_step(1'b0, 1'b1, 64'd0, 64'd0, 64'hAA);
    check_outs("one_elem", 1'b1, 1'b1, 1'b1, 64'hAA);
    drive_step(1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    check_outs("one_after", 1'b0, 1'b0, 1'b0, 64'hAA);
    last_k = 64'hAA;

    run_transfer(9, 9, 20, 1'b1);
    for (int t = 0; t < 25; t++)
      run_transfer($urandom_range(4), $urandom_range(5), $urandom_range(60), 1'($urandom_range(1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
